spi_bank_arbiter: RTL
=====================

// Module: spi_bank_arbiter
// PURPOSE
//   Round-robin scheduler that shares the single write port of the SPI MISO register bank between
//   N sensor producers (wheel speed, odometers, colour sensor, ...). Writes are frozen while an SPI
//   transaction is active (CS low), so the Pi never reads a word torn mid-transfer. Sits between
//   the sensor blocks and the SPI slave's MISO bank.
// PARAMETERS
//   N_REQ      4    number of requesters (2..8)
//   DW         32   bank data width
//   AW         4    bank address width (16 words)
//   FREEZE_MAX 1023 max frozen cycles before timeout (used only with SPI_ARB_FREEZE_TIMEOUT_EN)
// PORTS
//   clk          in   1         system clock
//   reset_n      in   1         asynchronous reset, active low
//   req_valid    in   N_REQ     requester i has a word to write
//   req_addr     in   N_REQ*AW  packed bank addresses, requester i at [i*AW +: AW]
//   req_data     in   N_REQ*DW  packed data, requester i at [i*DW +: DW]
//   req_ready    out  N_REQ     one-hot grant; a transfer occurs when req_valid[i] && req_ready[i]
//   spi_cs       in   1         raw SPI chip select from the Pi, active low, asynchronous
//   bank_we      out  1         bank write strobe, one cycle
//   bank_addr    out  AW        bank write address
//   bank_data    out  DW        bank write data
//   frozen       out  1         1 while writes are held off by CS
//   timeout_err  out  1         CS held low longer than FREEZE_MAX (0 when macro is off)
// BEHAVIOUR
//   - Reset: req_ready=0, bank_we=0, bank_addr=0, bank_data=0, frozen=0, timeout_err=0,
//     RR pointer=N_REQ-1 (requester 0 has top priority first); sync flops set to 1 (CS idle).
//   - spi_cs passes through a 2-flop synchroniser -> cs_s. Nothing else uses raw spi_cs.
//   - FSM states RUN, FROZEN, TOUT:
//       RUN    -> FROZEN when cs_s==0
//       FROZEN -> RUN when cs_s==1; -> TOUT when frozen count reaches FREEZE_MAX (macro only)
//       TOUT   -> RUN when cs_s==1
//   - frozen = (state==FROZEN), registered output.
//   - Grant (combinational from registered state/pointer): in RUN or TOUT, req_ready has one bit
//     set = first i with req_valid[i], searching from pointer+1 upward with wrap modulo N_REQ.
//     No valid requester -> req_ready=0. In FROZEN, req_ready=0.
//   - On handshake of i: next cycle bank_we=1, bank_addr/bank_data = requester i's fields,
//     pointer <= i. Latency 1 cycle; throughput 1 write per cycle; bank_addr/data hold when idle.
//   - A handshake in the last RUN cycle still issues its bank_we one cycle later (during FROZEN).
//     That is the only write allowed while frozen=1.
//   - Requesters must hold valid/addr/data stable until handshake. Freezing never drops or
//     reorders a request; the pointer is preserved across FROZEN.
//   - Two requesters writing the same address: both writes issue in grant order; last wins.
//   - reset_n asserted mid-operation: all outputs return to reset values immediately (async);
//     any pending transfer is lost; requesters re-present after reset.
// CONFIGURATION
//   SPI_ARB_FREEZE_TIMEOUT_EN defined:
//     - Adds a frozen-cycle counter, cleared on entry to FROZEN.
//     - When the counter reaches FREEZE_MAX: state goes to TOUT, timeout_err=1, grants resume.
//       This protects the sensor pipeline from a stuck CS line.
//     - timeout_err clears on the cycle state leaves TOUT.
//   SPI_ARB_FREEZE_TIMEOUT_EN undefined:
//     - No counter and no TOUT state; FROZEN lasts until cs_s==1.
//     - timeout_err is tied 0.
// TESTING
//   1 reset_n=0 with random inputs -> every output at its reset value; ready stays 0 while reset held.
//   2 after reset, req_valid=4'b0101 held, cs high -> req_ready 0001 then 0100 on consecutive cycles;
//     bank_we on cycles 2,3 with addr/data of req0 then req2.
//   3 req_valid=4'b1111 held 8 cycles -> grant order 0,1,2,3,0,1,2,3; bank_we high 8 consecutive cycles.
//   4 spi_cs low for 20 cycles while req1 valid -> frozen=1 and ready=0 from cycle 2 (sync) for
//     20 cycles; req1 is granted on the first cycle after frozen falls, with pointer preserved.
//   5 macro on, FREEZE_MAX=16, spi_cs low 40 cycles -> timeout_err=1 after 16 frozen cycles and
//     grants resume; timeout_err=0 two cycles after spi_cs rises.
//   6 reset_n pulsed during the burst of scenario 3 -> bank_we=0 immediately; priority restarts at 0.

Source files
------------

// File: rtl/spi_bank_arbiter_if.sv
// Bus bundle between the sensor producers / SPI chip select and the MISO-bank write arbiter.
interface spi_bank_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                spi_cs;
    logic                bank_we;
    logic [AW-1:0]       bank_addr;
    logic [DW-1:0]       bank_data;
    logic                frozen;
    logic                timeout_err;

    modport master (
        output req_valid, req_addr, req_data, spi_cs,
        input  req_ready, bank_we, bank_addr, bank_data, frozen, timeout_err
    );

    modport slave (
        input  req_valid, req_addr, req_data, spi_cs,
        output req_ready, bank_we, bank_addr, bank_data, frozen, timeout_err
    );
endinterface

// File: rtl/spi_bank_arbiter.sv
// Round-robin arbiter for the SPI MISO bank write port; writes freeze while CS is low.
// Optional stuck-CS timeout enabled by defining SPI_ARB_FREEZE_TIMEOUT_EN.
module spi_bank_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 4,
    parameter int unsigned FREEZE_MAX = 1023
) (
    input  logic             clk,
    input  logic             reset_n,
    spi_bank_arbiter_if.slave bus
);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef SPI_ARB_FREEZE_TIMEOUT_EN
    localparam int unsigned CW = $clog2(FREEZE_MAX + 1);
    typedef enum logic [1:0] {RUN = 2'd0, FROZEN = 2'd1, TOUT = 2'd2} state_e;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [0:0] {RUN = 1'b0, FROZEN = 1'b1} state_e;
`endif

    state_e         state_q, state_d;
    logic           cs_meta_q, cs_s_q;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic           bank_we_q, bank_we_d;
    logic [AW-1:0]  bank_addr_q, bank_addr_d;
    logic [DW-1:0]  bank_data_q, bank_data_d;
    logic           frozen_q, frozen_d;
    logic           timeout_err_q, timeout_err_d;
    logic           grant_vld_c;
    logic [PW-1:0]  grant_idx_c;
    logic [N_REQ-1:0] grant_c;

    // Two-flop CS synchroniser, idle high out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta_q <= 1'b1;
            cs_s_q    <= 1'b1;
        end else begin
            cs_meta_q <= bus.spi_cs;
            cs_s_q    <= cs_meta_q;
        end
    end

    // First valid requester after the pointer, wrapping; smallest offset wins.
    always_comb begin
        logic [PW-1:0] cand;
        cand        = '0;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        if (state_q != FROZEN) begin
            for (int k = int'(N_REQ); k >= 1; k--) begin
                cand = PW'((int'(ptr_q) + k) % int'(N_REQ));
                if (bus.req_valid[cand]) begin
                    grant_vld_c = 1'b1;
                    grant_idx_c = cand;
                end
            end
        end
    end

    assign grant_c = grant_vld_c ? (N_REQ'(1) << grant_idx_c) : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        bank_we_d   = 1'b0;
        bank_addr_d = bank_addr_q;
        bank_data_d = bank_data_q;
`ifdef SPI_ARB_FREEZE_TIMEOUT_EN
        cnt_d       = (state_q == FROZEN) ? cnt_q + CW'(1) : '0;
`endif
        if (grant_vld_c) begin
            bank_we_d   = 1'b1;
            bank_addr_d = bus.req_addr[int'(grant_idx_c)*int'(AW) +: AW];
            bank_data_d = bus.req_data[int'(grant_idx_c)*int'(DW) +: DW];
            ptr_d       = grant_idx_c;
        end
        case (state_q)
            RUN:    if (!cs_s_q) state_d = FROZEN;
            FROZEN: begin
                if (cs_s_q) state_d = RUN;
`ifdef SPI_ARB_FREEZE_TIMEOUT_EN
                else if (cnt_q == CW'(FREEZE_MAX - 1)) state_d = TOUT;
`endif
            end
`ifdef SPI_ARB_FREEZE_TIMEOUT_EN
            TOUT:   if (cs_s_q) state_d = RUN;
`endif
            default: state_d = RUN;
        endcase
        frozen_d = (state_d == FROZEN);
`ifdef SPI_ARB_FREEZE_TIMEOUT_EN
        timeout_err_d = (state_d == TOUT);
`else
        timeout_err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            ptr_q         <= PW'(N_REQ - 1);
            bank_we_q     <= 1'b0;
            bank_addr_q   <= '0;
            bank_data_q   <= '0;
            frozen_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            bank_we_q     <= bank_we_d;
            bank_addr_q   <= bank_addr_d;
            bank_data_q   <= bank_data_d;
            frozen_q      <= frozen_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef SPI_ARB_FREEZE_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif

    // Grants are suppressed while reset is held.
    assign bus.req_ready   = grant_c & {N_REQ{reset_n}};
    assign bus.bank_we     = bank_we_q;
    assign bus.bank_addr   = bank_addr_q;
    assign bus.bank_data   = bank_data_q;
    assign bus.frozen      = frozen_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
